// File: rtl/mux_arbiter.sv
// Round-robin 4-way arbiter driving a registered 4:1 mux select/enable.
// Optional MUX_ARB_TIMEOUT_EN bounds each grant to TIMEOUT cycles.
module mux_arbiter #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       en,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       mux_en,
  output logic       busy
);

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_GRANT = 1'b1;

  logic       state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       men_q, men_d;

  logic [1:0] win;
  logic       win_vld;
  logic [1:0] idx;
  logic       to_hit;
  logic       rel;

  // Pick first requester at or after ptr; scan high offset to low
  always_comb begin
    win     = ptr_q;
    win_vld = 1'b0;
    idx     = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Hold counter: zero on the first grant cycle, +1 per grant cycle
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE) cnt_d = 8'd0;
    else                   cnt_d = cnt_q + 8'd1;
  end

  // Hold counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

  assign to_hit = (state_q == S_GRANT) && (cnt_q == 8'(TIMEOUT - 1));
`else
  // Grant duration is unlimited; TIMEOUT only matters with the timeout build
  assign to_hit = 1'b0 & (TIMEOUT > 255);
`endif

  assign rel = !en || !req[sel_q] || to_hit;

  // Next-state: grant from IDLE, hold or release in GRANT
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    men_d   = men_q;
    unique case (state_q)
      S_IDLE: begin
        if (en && win_vld) begin
          state_d = S_GRANT;
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          men_d   = 1'b1;
        end else begin
          gnt_d = 4'b0000;
          sel_d = 2'd0;
          men_d = 1'b0;
        end
      end
      S_GRANT: begin
        if (rel) begin
          state_d = S_IDLE;
          ptr_d   = sel_q + 2'd1;
          gnt_d   = 4'b0000;
          sel_d   = 2'd0;
          men_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      men_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      men_q   <= men_d;
    end
  end

  assign gnt    = gnt_q;
  assign sel    = sel_q;
  assign mux_en = men_q;
  assign busy   = (state_q == S_GRANT);

endmodule
